// File: rtl/fpnew_slice_arbiter.sv
// Purpose : shares one FPU format-slice between NumReq issue ports; round-robin
//           grant (fixed priority with FPNEW_SLICE_ARB_STRICT_PRIO_EN defined),
//           an in-order owner-ID FIFO, and result routing back to the owning port.
// Latency : zero added; request->slice and slice->response are combinational.
// Backpr. : a port is accepted only when the slice is ready, fewer than MaxInFlight
//           ops are outstanding and no flush is active; the slice output stalls
//           on the head owner's rsp_ready_i (in-order stall).
// Ports   : clk_i/rst_i (async, active-high)/flush_i; req_* issue side (per port);
//           rsp_* response side (valid/ready per port, shared data bus);
//           slc_* slice side (slc_flush forwards flush_i); busy_o.
// Macro   : FPNEW_SLICE_ARB_STRICT_PRIO_EN selects lowest-index-wins priority.
module fpnew_slice_arbiter #(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned Width       = 32,
  parameter int unsigned NumOperands = 3,
  parameter int unsigned MaxInFlight = 4,
  // operation_e(4) + op_mod(1) + rnd_mode(3) + vectorial(1) + simd_mask(1)
  parameter int unsigned OpWidth     = 10,
  parameter type         TagType     = logic
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          flush_i,
  // issue ports
  input  logic [NumReq-1:0]                             req_valid_i,
  output logic [NumReq-1:0]                             req_ready_o,
  input  logic [NumReq-1:0][NumOperands-1:0][Width-1:0] req_operands_i,
  input  logic [NumReq-1:0][OpWidth-1:0]                req_op_i,
  input  TagType [NumReq-1:0]                           req_tag_i,
  // response ports
  output logic [NumReq-1:0]                             rsp_valid_o,
  input  logic [NumReq-1:0]                             rsp_ready_i,
  output logic [Width-1:0]                              rsp_result_o,
  output logic [4:0]                                    rsp_status_o,
  output TagType                                        rsp_tag_o,
  // slice input side
  output logic [NumOperands-1:0][Width-1:0]             slc_operands,
  output logic [OpWidth-1:0]                            slc_op,
  output TagType                                        slc_in_tag,
  output logic                                          slc_in_valid,
  input  logic                                          slc_in_ready,
  output logic                                          slc_flush,
  // slice output side
  input  logic [Width-1:0]                              slc_result,
  input  logic [4:0]                                    slc_status,
  input  TagType                                        slc_out_tag,
  input  logic                                          slc_out_valid,
  output logic                                          slc_out_ready,
  input  logic                                          slc_busy,
  output logic                                          busy_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW = $clog2(MaxInFlight);
  localparam int unsigned CntW = PtrW + 1;

  logic [IdxW-1:0]                  gidx;
  logic                             any_valid;
  logic [NumReq-1:0]                grant;
  logic                             full, empty, issue_ok, push, pop;
  logic [CntW-1:0]                  cnt_q;
  logic [PtrW-1:0]                  wr_ptr_q, rd_ptr_q;
  logic [MaxInFlight-1:0][IdxW-1:0] id_q;
  logic [IdxW-1:0]                  head;

  // ---------------- grant ----------------
`ifdef FPNEW_SLICE_ARB_STRICT_PRIO_EN
  always_comb begin
    gidx      = '0;
    any_valid = 1'b0;
    // scan downwards so the lowest valid index is the last to win
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        gidx      = IdxW'(i);
        any_valid = 1'b1;
      end
    end
  end
`else
  logic [IdxW-1:0] rr_ptr_q;
  int              cand;

  always_comb begin
    gidx      = '0;
    any_valid = 1'b0;
    cand      = 0;
    // scan offsets downwards so the smallest offset from rr_ptr wins
    for (int i = NumReq - 1; i >= 0; i--) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= int'(NumReq)) cand = cand - int'(NumReq);
      if (req_valid_i[cand]) begin
        gidx      = IdxW'(cand);
        any_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
    end else if (flush_i) begin
      rr_ptr_q <= '0;
    end else if (push) begin
      rr_ptr_q <= (gidx == IdxW'(NumReq - 1)) ? '0 : gidx + IdxW'(1);
    end
  end
`endif

  assign grant = NumReq'(any_valid) << gidx;

  // ---------------- slice request ----------------
  // rst_i gates the issue side so outputs drop to idle as soon as reset asserts
  assign full     = (cnt_q == CntW'(MaxInFlight));
  assign empty    = (cnt_q == '0);
  assign issue_ok = !full && !flush_i && !rst_i;

  assign slc_operands = req_operands_i[gidx];
  assign slc_op       = req_op_i[gidx];
  assign slc_in_tag   = req_tag_i[gidx];
  assign slc_in_valid = any_valid && issue_ok;
  assign slc_flush    = flush_i;

  assign push        = slc_in_valid && slc_in_ready;
  assign req_ready_o = grant & {NumReq{slc_in_ready && issue_ok}};

  // ---------------- result routing ----------------
  assign head          = id_q[rd_ptr_q];
  // an empty FIFO means nobody owns the output: sink it so the slice never hangs
  assign slc_out_ready = empty || rsp_ready_i[head];
  assign rsp_valid_o   = NumReq'(slc_out_valid && !empty) << head;
  assign rsp_result_o  = slc_result;
  assign rsp_status_o  = slc_status;
  assign rsp_tag_o     = slc_out_tag;
  assign pop           = slc_out_valid && !empty && rsp_ready_i[head] && !flush_i;

  assign busy_o = !empty || slc_busy;

  // ---------------- owner-ID FIFO ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // storage needs no reset: entries are only read while counted
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) id_q[wr_ptr_q] <= gidx;
  end

  // a slice result with no recorded owner indicates a slice/arbiter mismatch
  a_no_orphan_result : assert property (@(posedge clk_i) disable iff (rst_i)
                                        !(slc_out_valid && empty));

endmodule

// File: tb/tb_fpnew_slice_arbiter.sv
module tb_fpnew_slice_arbiter;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   flush_i;
  logic [1:0]             req_valid_i;
  logic [1:0]             req_ready_o;
  logic [1:0][2:0][31:0]  req_operands_i;
  logic [1:0][9:0]        req_op_i;
  logic [1:0][7:0]        req_tag_i;
  logic [1:0]             rsp_valid_o;
  logic [1:0]             rsp_ready_i;
  logic [31:0]            rsp_result_o;
  logic [4:0]             rsp_status_o;
  logic [7:0]             rsp_tag_o;
  logic [2:0][31:0]       slc_operands;
  logic [9:0]             slc_op;
  logic [7:0]             slc_in_tag;
  logic                   slc_in_valid;
  logic                   slc_in_ready;
  logic                   slc_flush;
  logic [31:0]            slc_result;
  logic [4:0]             slc_status;
  logic [7:0]             slc_out_tag;
  logic                   slc_out_valid;
  logic                   slc_out_ready;
  logic                   slc_busy;
  logic                   busy_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  fpnew_slice_arbiter #(
    .NumReq(2), .Width(32), .NumOperands(3), .MaxInFlight(4), .OpWidth(10),
    .TagType(logic [7:0])
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_operands_i(req_operands_i), .req_op_i(req_op_i), .req_tag_i(req_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o), .rsp_tag_o(rsp_tag_o),
    .slc_operands(slc_operands), .slc_op(slc_op), .slc_in_tag(slc_in_tag),
    .slc_in_valid(slc_in_valid), .slc_in_ready(slc_in_ready), .slc_flush(slc_flush),
    .slc_result(slc_result), .slc_status(slc_status), .slc_out_tag(slc_out_tag),
    .slc_out_valid(slc_out_valid), .slc_out_ready(slc_out_ready),
    .slc_busy(slc_busy), .busy_o(busy_o)
  );

  // Slice model: 2-cycle latency, elastic queue, always ready. result = op0 + 1.
  int          s_wp, s_rp, s_cyc;
  logic [7:0]  s_tag [16];
  logic [31:0] s_res [16];
  int          s_t   [16];

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_wp <= 0; s_rp <= 0; s_cyc <= 0;
    end else begin
      s_cyc <= s_cyc + 1;
      if (slc_flush) begin
        s_wp <= 0; s_rp <= 0;
      end else begin
        if (slc_in_valid && slc_in_ready) s_wp <= s_wp + 1;
        if (slc_out_valid && slc_out_ready) s_rp <= s_rp + 1;
      end
    end
  end

  always @(posedge clk_i) begin
    if (slc_in_valid && slc_in_ready && !slc_flush && !rst_i) begin
      s_tag[s_wp % 16] <= slc_in_tag;
      s_res[s_wp % 16] <= slc_operands[0] + 32'd1;
      s_t[s_wp % 16]   <= s_cyc + 2;
    end
  end

  assign slc_in_ready  = 1'b1;
  assign slc_out_valid = (s_rp != s_wp) && (s_t[s_rp % 16] <= s_cyc);
  assign slc_out_tag   = s_tag[s_rp % 16];
  assign slc_result    = s_res[s_rp % 16];
  assign slc_status    = 5'h0;
  assign slc_busy      = (s_rp != s_wp);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic v0, input logic [7:0] t0,
                         input logic v1, input logic [7:0] t1);
    req_valid_i          = {v1, v0};
    req_tag_i[0]         = t0;
    req_tag_i[1]         = t1;
    req_operands_i[0][0] = 32'h100 + {24'h0, t0};
    req_operands_i[1][0] = 32'h100 + {24'h0, t1};
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    flush_i = 1'b0;
    rsp_ready_i = 2'b11;
    set_req(1'b0, 8'h0, 1'b0, 8'h0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  // expected in-flight count per cycle of the full-FIFO sequence
  int exp_cnt [12] = '{0, 1, 2, 3, 4, 4, 4, 3, 3, 2, 1, 0};

  initial begin
    req_operands_i = '0;
    req_op_i       = '0;
    do_reset();

    // reset state
    @(negedge clk_i);
    chk("rst_req_ready",  {30'h0, req_ready_o}, 32'h0);
    chk("rst_rsp_valid",  {30'h0, rsp_valid_o}, 32'h0);
    chk("rst_in_valid",   {31'h0, slc_in_valid}, 32'h0);
    chk("rst_out_ready",  {31'h0, slc_out_ready}, 32'h1);
    chk("rst_busy",       {31'h0, busy_o}, 32'h0);
    next_cycle();

    // single port: 4 back-to-back ops, responses 2 cycles later in order
    req_op_i[0] = 10'h155;
    for (int c = 0; c < 6; c++) begin
      set_req(c < 4, 8'(c), 1'b0, 8'h0);
      @(negedge clk_i);
      chk("sp_req_ready", {30'h0, req_ready_o}, (c < 4) ? 32'h1 : 32'h0);
      chk("sp_rsp_valid", {30'h0, rsp_valid_o}, (c >= 2) ? 32'h1 : 32'h0);
      if (c == 0) chk("sp_op_mux", {22'h0, slc_op}, 32'h155);
      if (c >= 2) begin
        chk("sp_tag",    {24'h0, rsp_tag_o}, 32'(c - 2));
        chk("sp_result", rsp_result_o, 32'h101 + 32'(c - 2));
      end
      next_cycle();
    end

    // fairness: both ports valid, grants alternate 0,1,0,1
    do_reset();
    for (int c = 0; c < 6; c++) begin
      set_req(c < 4, 8'h10 + 8'(c), c < 4, 8'h20 + 8'(c));
      @(negedge clk_i);
      chk("rr_req_ready", {30'h0, req_ready_o},
          (c >= 4) ? 32'h0 : ((c % 2 == 1) ? 32'h2 : 32'h1));
      if (c >= 2) begin
        chk("rr_rsp_valid", {30'h0, rsp_valid_o}, ((c - 2) % 2 == 1) ? 32'h2 : 32'h1);
        chk("rr_tag", {24'h0, rsp_tag_o},
            ((c - 2) % 2 == 1) ? 32'h20 + 32'(c - 2) : 32'h10 + 32'(c - 2));
      end
      next_cycle();
    end

    // full: 4 accepts stall, pops resume one per cycle, accept only after first pop
    do_reset();
    for (int c = 0; c < 12; c++) begin
      set_req(c < 8, (c < 4) ? 8'(c) : 8'd4, 1'b0, 8'h0);
      rsp_ready_i = (c >= 6) ? 2'b11 : 2'b00;
      @(negedge clk_i);
      chk("full_cnt", {29'h0, dut.cnt_q}, 32'(exp_cnt[c]));
      chk("full_req_ready", {30'h0, req_ready_o}, (c < 4 || c == 7) ? 32'h1 : 32'h0);
      chk("full_rsp_valid", {30'h0, rsp_valid_o}, (c >= 2 && c <= 10) ? 32'h1 : 32'h0);
      if (c == 4) chk("full_in_valid", {31'h0, slc_in_valid}, 32'h0);
      if (c >= 6 && c <= 10) chk("full_tag", {24'h0, rsp_tag_o}, 32'(c - 6));
      next_cycle();
    end

    // result backpressure: head owned by port 1 (not ready) blocks port 0
    do_reset();
    rsp_ready_i = 2'b01;
    set_req(1'b0, 8'h0, 1'b1, 8'h21);
    @(negedge clk_i);
    chk("bp_grant1", {30'h0, req_ready_o}, 32'h2);
    next_cycle();
    set_req(1'b1, 8'h11, 1'b0, 8'h0);
    @(negedge clk_i);
    chk("bp_grant0", {30'h0, req_ready_o}, 32'h1);
    next_cycle();
    set_req(1'b0, 8'h0, 1'b0, 8'h0);
    for (int c = 2; c < 5; c++) begin
      @(negedge clk_i);
      chk("bp_rsp_valid", {30'h0, rsp_valid_o}, 32'h2);
      chk("bp_out_ready", {31'h0, slc_out_ready}, 32'h0);
      next_cycle();
    end
    rsp_ready_i = 2'b11;
    @(negedge clk_i);
    chk("bp_rel_valid1", {30'h0, rsp_valid_o}, 32'h2);
    chk("bp_rel_tag1", {24'h0, rsp_tag_o}, 32'h21);
    next_cycle();
    @(negedge clk_i);
    chk("bp_rel_valid0", {30'h0, rsp_valid_o}, 32'h1);
    chk("bp_rel_tag0", {24'h0, rsp_tag_o}, 32'h11);
    next_cycle();

    // flush with 3 ops in flight
    do_reset();
    rsp_ready_i = 2'b00;
    for (int c = 0; c < 3; c++) begin
      set_req(1'b1, 8'(c), 1'b0, 8'h0);
      next_cycle();
    end
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("fl_in_valid", {31'h0, slc_in_valid}, 32'h0);
    chk("fl_req_ready", {30'h0, req_ready_o}, 32'h0);
    next_cycle();
    flush_i = 1'b0;
    set_req(1'b0, 8'h0, 1'b0, 8'h0);
    @(negedge clk_i);
    chk("fl_cnt", {29'h0, dut.cnt_q}, 32'h0);
    chk("fl_busy", {31'h0, busy_o}, {31'h0, slc_busy});
    chk("fl_busy_idle", {31'h0, busy_o}, 32'h0);
    chk("fl_rsp_valid", {30'h0, rsp_valid_o}, 32'h0);
    next_cycle();
    rsp_ready_i = 2'b11;
    set_req(1'b1, 8'h30, 1'b1, 8'h40);
    @(negedge clk_i);
    chk("fl_rr_reset", {30'h0, req_ready_o}, 32'h1);
    chk("fl_no_rsp", {30'h0, rsp_valid_o}, 32'h0);
    next_cycle();

`ifdef FPNEW_SLICE_ARB_STRICT_PRIO_EN
    // fixed priority: port 0 wins every cycle
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_req(1'b1, 8'(c), 1'b1, 8'h20 + 8'(c));
      @(negedge clk_i);
      chk("sp_prio_grant", {30'h0, req_ready_o}, 32'h1);
      next_cycle();
    end
`endif

    // reset mid-operation: outputs go idle asynchronously
    do_reset();
    rsp_ready_i = 2'b00;
    for (int c = 0; c < 2; c++) begin
      set_req(1'b1, 8'(c), 1'b0, 8'h0);
      next_cycle();
    end
    @(negedge clk_i);
    chk("rm_pre_valid", {30'h0, rsp_valid_o}, 32'h1);
    #1;
    rst_i = 1'b1;
    #1;
    chk("rm_req_ready", {30'h0, req_ready_o}, 32'h0);
    chk("rm_rsp_valid", {30'h0, rsp_valid_o}, 32'h0);
    chk("rm_in_valid", {31'h0, slc_in_valid}, 32'h0);
    chk("rm_out_ready", {31'h0, slc_out_ready}, 32'h1);
    chk("rm_busy", {31'h0, busy_o}, 32'h0);
    chk("rm_cnt", {29'h0, dut.cnt_q}, 32'h0);
    set_req(1'b0, 8'h0, 1'b0, 8'h0);
    next_cycle();
    rst_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
